// File: rtl/ha_array_accumulator_if.sv
// Handshake bundle between an ha_array multiplier front end, the row accumulator
// and the downstream product consumer.
interface ha_array_accumulator_if #(
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       ha_array_0_b;
  logic [8:0]       ha_array_0_t;
  logic [6:0]       ha_array_1_b;
  logic [8:0]       ha_array_1_t;
  logic [6:0]       ha_array_2_b;
  logic [8:0]       ha_array_2_t;
  logic [6:0]       ha_array_3_b;
  logic [8:0]       ha_array_3_t;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] product;
  logic             overflow;

  modport slave (
    input  in_valid,
    input  ha_array_0_b, ha_array_0_t, ha_array_1_b, ha_array_1_t,
    input  ha_array_2_b, ha_array_2_t, ha_array_3_b, ha_array_3_t,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product,
    output overflow
  );

  modport master (
    output in_valid,
    output ha_array_0_b, ha_array_0_t, ha_array_1_b, ha_array_1_t,
    output ha_array_2_b, ha_array_2_t, ha_array_3_b, ha_array_3_t,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product,
    input  overflow
  );
endinterface

// File: rtl/ha_array_accumulator.sv
// Sequential back end of the ha_array multiplier: folds the four captured
// half-adder rows into the product, one row per cycle.
module ha_array_accumulator #(
  parameter int OUT_W    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ha_array_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_q;
  logic [1:0]       cnt_q;
  logic [OUT_W:0]   acc_q;
  logic [OUT_W:0]   acc_d;
  logic [OUT_W:0]   row_sh;
  logic [9:0]       row_sel;
  logic [6:0]       b_q [4];
  logic [8:0]       t_q [4];
  logic             out_valid_q;
  logic [OUT_W-1:0] product_q;
  logic             overflow_q;
  logic             accept;

  // b[i] carries weight 2^(i+2) inside its row, t[i] weight 2^i.
  function automatic logic [9:0] row_value(input logic [6:0] b, input logic [8:0] t);
    return 10'(t) + 10'({b, 2'b00});
  endfunction

  function automatic logic [OUT_W-1:0] sat_product(input logic [OUT_W:0] acc);
    if (SATURATE && acc[OUT_W]) return '1;
    return acc[OUT_W-1:0];
  endfunction

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.overflow  = overflow_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign row_sel = row_value(b_q[cnt_q], t_q[cnt_q]);
  assign row_sh  = (OUT_W+1)'(row_sel) << {cnt_q, 1'b0};
  assign acc_d   = acc_q + row_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      overflow_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        b_q[k] <= '0;
        t_q[k] <= '0;
      end
    end else begin
      // in_ready is only high in IDLE/DONE, so accept also covers the back-to-back case
      if (accept) begin
        b_q[0] <= bus.ha_array_0_b;  t_q[0] <= bus.ha_array_0_t;
        b_q[1] <= bus.ha_array_1_b;  t_q[1] <= bus.ha_array_1_t;
        b_q[2] <= bus.ha_array_2_b;  t_q[2] <= bus.ha_array_2_t;
        b_q[3] <= bus.ha_array_3_b;  t_q[3] <= bus.ha_array_3_t;
        acc_q  <= '0;
        cnt_q  <= 2'd0;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= ACC;
        end
        ACC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            product_q   <= sat_product(acc_d);
            overflow_q  <= acc_d[OUT_W];
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= accept ? ACC : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ha_array_accumulator.md
Name: ha_array_accumulator

Overview:
- Back end of the ha_array partial-product interface.
- Takes the four approximate half-adder rows produced by an unsigned 8x8 ha_array multiplier front end (rows ha_array_0..3, each with a 7-bit b vector and a 9-bit t vector). Accumulates them sequentially, one row per cycle, into the final product.
- Uses a valid/ready handshake on both sides, so it can sit behind a registered front end and drive a streaming consumer.

Parameters:
- OUT_W, 16: product width. Accumulator width is OUT_W+1.
- SATURATE, 0: 0 = product wraps modulo 2^OUT_W; 1 = product clamps to all-ones on overflow.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  row bundle valid
- in_ready  output  1  block can accept a bundle
- ha_array_0_b  input  7  row 0 carry vector
- ha_array_0_t  input  9  row 0 sum vector
- ha_array_1_b  input  7  row 1 carry vector
- ha_array_1_t  input  9  row 1 sum vector
- ha_array_2_b  input  7  row 2 carry vector
- ha_array_2_t  input  9  row 2 sum vector
- ha_array_3_b  input  7  row 3 carry vector
- ha_array_3_t  input  9  row 3 sum vector
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  OUT_W  accumulated product
- overflow  output  1  unclamped sum exceeded 2^OUT_W-1 (valid with out_valid)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Row weighting: t[i] has weight 2^i; b[i] has weight 2^(i+2).
  - row_k value = t_k + (b_k << 2), range 0..1019, 10 bits.
  - Row k contributes row_k << 2k.
  - Sum = row_0 + 4*row_1 + 16*row_2 + 64*row_3, computed exactly in an OUT_W+1-bit accumulator.
- Reset values: state=IDLE, in_ready=1, out_valid=0, product=0, overflow=0, accumulator=0, row counter=0, captured rows=0.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture all eight vectors, clear accumulator, counter=0, go to ACC.
- ACC:
  - in_ready=0.
  - Each edge adds row[counter] << 2*counter into the accumulator, then increments counter.
  - After the edge that adds row 3, go to DONE.
  - Exactly 4 cycles are spent in ACC.
- DONE:
  - out_valid=1.
  - product = low OUT_W bits of the accumulator, or all-ones if SATURATE=1 and the accumulator MSB is set.
  - overflow = accumulator MSB.
  - product and overflow stay stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises on the 5th rising edge after the accept edge (accept edge, then 4 ACC edges).
- Throughput: one product per 5 cycles.
- Back-to-back: in DONE, in_ready = out_ready.
  - If out_valid&out_ready and in_valid are all high on the same edge, the new bundle is captured and the FSM goes directly to ACC. out_valid drops on that edge.
- Out handshake without a new bundle: out_valid&out_ready with in_valid=0 goes to IDLE; out_valid drops.
- Input changes: changes on the ha_array inputs outside the accept edge are ignored. Captured copies are used for the whole accumulation.
- in_valid while busy: in_valid high in ACC is not accepted. The producer must hold in_valid and the data until in_ready.
- Reset mid-operation: rst_n low in any state immediately forces all outputs to reset values. The partial accumulation is discarded and no stale out_valid follows.
- No combinational path from in_valid to out_valid. in_ready depends combinationally only on state and out_ready.

Test Plan:
- Reset then single bundle, all vectors zero -> out_valid exactly 5 cycles after accept; product=0, overflow=0.
- Only ha_array_0_t=9'h001 -> product=1. Only ha_array_3_b=7'h40 (weight 2^14) -> product=16384, overflow=0.
- All b=7'h7F and all t=9'h1FF -> sum 86615.
  - SATURATE=0: product=21079, overflow=1.
  - SATURATE=1: product=65535, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, toggling the input buses -> product stable, in_ready=0. Release with in_valid=1 -> new bundle accepted on the same edge; next product 5 edges later.
- Streaming: 50 random bundles with in_valid and out_ready both held high -> one product per 5 cycles; each product equals the reference-model sum mod 2^16, in order.
- Assert rst_n low during the 2nd ACC cycle -> out_valid=0, in_ready=1 immediately. No product emerges for the aborted bundle; the next bundle computes correctly.
